// File: rtl/mem_responder.sv
// mem_responder: 256x32 word-memory target with a valid/ready request channel
// and a one-cycle response strobe. Owns the stack pointer for PUSH/POP.
// Optional feature macro: MEM_STACK_EN (defined: live sp and PUSH/POP;
// undefined: ops 3/4 are illegal and sp is tied to SP_RESET).
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [7:0]  SP_RESET    = 8'h00,
  parameter logic [7:0]  STACK_LIMIT = 8'hC0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  sp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_FETCH = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem [DEPTH];

`ifdef MEM_STACK_EN
  logic [7:0]  sp_q, sp_d;
`else
  logic        unused_stack_cfg;
  assign unused_stack_cfg = ^STACK_LIMIT;
`endif

  // Next-state, request capture, single array operation and response data.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    mem_wdata   = wdata_q;
`ifdef MEM_STACK_EN
    sp_d        = sp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_ACCESS;
          op_d        = op_e'(req_op);
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
        end
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (op_q)
          OP_FETCH, OP_LOAD: rsp_rdata_d = mem[addr_q];
          OP_STORE:          mem_we = 1'b1;
`ifdef MEM_STACK_EN
          OP_PUSH: begin
            if (sp_q == STACK_LIMIT) begin
              rsp_err_d = 1'b1;
            end else begin
              sp_d      = sp_q - 8'd1;
              mem_we    = 1'b1;
              mem_waddr = sp_q - 8'd1;
            end
          end
          OP_POP: begin
            if (sp_q == SP_RESET) begin
              rsp_err_d = 1'b1;
            end else begin
              rsp_rdata_d = mem[sp_q];
              sp_d        = sp_q + 8'd1;
            end
          end
`endif
          default: rsp_err_d = 1'b1;
        endcase
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Control, capture and response registers; reset drops outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef MEM_STACK_EN
  // Stack pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= SP_RESET;
    else        sp_q <= sp_d;
  end
  assign sp = sp_q;
`else
  assign sp = SP_RESET;
`endif

  // Storage array; not reset. The write enable is only raised in ACCESS, so
  // a reset before the access edge forces IDLE and discards the write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// requests against a behavioural memory/stack model. Honours MEM_STACK_EN.
module tb_mem_responder;

  localparam logic [7:0] SP_RST = 8'h00;
  localparam logic [7:0] LIMIT  = 8'hC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  sp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_mem [256];
  logic [7:0]  ref_sp;

  mem_responder #(
    .DEPTH(256),
    .SP_RESET(SP_RST),
    .STACK_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural effect of one request on memory and stack.
  task automatic model(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    err = 1'b0;
    rd  = '0;
    if (op == 3'd0 || op == 3'd1) begin
      rd = ref_mem[addr];
    end else if (op == 3'd2) begin
      ref_mem[addr] = wd;
`ifdef MEM_STACK_EN
    end else if (op == 3'd3) begin
      if (ref_sp == LIMIT) err = 1'b1;
      else begin
        ref_sp = 8'((int'(ref_sp) + 255) % 256);
        ref_mem[ref_sp] = wd;
      end
    end else if (op == 3'd4) begin
      if (ref_sp == SP_RST) err = 1'b1;
      else begin
        rd = ref_mem[ref_sp];
        ref_sp = 8'((int'(ref_sp) + 1) % 256);
      end
`endif
    end else begin
      err = 1'b1;
    end
  endtask

  // One full request/response with edge-exact timing checks.
  task automatic xact(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wd);
    logic        e;
    logic [31:0] r;
    model(op, addr, wd, e, r);
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_access", req_ready, 0);
    check("no_early_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, e);
    check("rsp_rdata", rsp_rdata, r);
    check("sp", sp, ref_sp);
    @(posedge clk); #1;
    check("rsp_pulse_end", rsp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  logic [7:0]  cur;
  logic [31:0] v;

  initial begin
    ref_sp = SP_RST;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_sp", sp, SP_RST);
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value.
    for (int a = 0; a < 256; a++) xact(3'd2, 8'(a), $urandom);

    // Store then load, read-after-write.
    xact(3'd2, 8'h10, 32'hDEADBEEF);
    xact(3'd1, 8'h10, 32'h0);
    check("raw_deadbeef", rsp_rdata === 32'h0 ? ref_mem[8'h10] : 32'h0, 32'hDEADBEEF);

`ifdef MEM_STACK_EN
    xact(3'd3, 8'h00, 32'h1); check("sp_push1", sp, 8'hFF);
    xact(3'd3, 8'h00, 32'h2); check("sp_push2", sp, 8'hFE);
    xact(3'd4, 8'h00, 32'h0); check("sp_pop1", sp, 8'hFF);
    xact(3'd4, 8'h00, 32'h0); check("sp_pop2", sp, 8'h00);
    xact(3'd4, 8'h00, 32'h0); check("sp_pop_empty", sp, 8'h00);
    for (int k = 0; k < 64; k++) xact(3'd3, 8'h00, $urandom);
    check("sp_at_limit", sp, 8'hC0);
    v = ref_mem[8'hBF];
    xact(3'd3, 8'h00, 32'hFFFF_0000);
    check("sp_overflow_hold", sp, 8'hC0);
    xact(3'd1, 8'hBF, 32'h0);
    check("bf_unchanged", ref_mem[8'hBF], v);
`else
    xact(3'd3, 8'h00, 32'h1234); check("sp_push_disabled", sp, 8'h00);
    xact(3'd4, 8'h00, 32'h0);    check("sp_pop_disabled", sp, 8'h00);
`endif
    xact(3'd6, 8'h33, 32'hCAFE_F00D);
    xact(3'd1, 8'h33, 32'h0);

    // Continuous request stream of fetches.
    @(negedge clk);
    check("stream_ready0", req_ready, 1);
    cur = 8'($urandom);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_addr  = cur;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("stream_ready", req_ready, 32'(i % 3 == 2));
      check("stream_valid", rsp_valid, 32'(i % 3 == 1));
      if (i % 3 == 1) check("stream_rdata", rsp_rdata, ref_mem[cur]);
      if (i % 3 == 2) begin
        cur = 8'($urandom);
        req_addr = cur;
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset before the access edge discards the store.
    xact(3'd2, 8'h20, 32'h5);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_addr = 8'h20; req_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_sp", sp, SP_RST);
    @(posedge clk); #1;
    check("rst_mid_no_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_sp = SP_RST;
    xact(3'd1, 8'h20, 32'h0);
    check("rst_store_discarded", ref_mem[8'h20], 32'h5);

    // Reset after the access edge keeps the completed write.
    v = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_addr = 8'h21; req_wdata = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("late_rst_rsp", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("late_rst_drop", rsp_valid, 0);
    ref_mem[8'h21] = v;
    ref_sp = SP_RST;
    @(negedge clk);
    rst_n = 1'b1;
    xact(3'd1, 8'h21, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      xact(3'($urandom_range(0, 7)), 8'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous 256×32 word-memory target that services the CPU's memory-phase and fetch-phase requests over a valid/ready request channel and a one-cycle response pulse. Sits between the phase-sequenced CPU datapath (instruction fetch, load, store, push, pop) and the storage array. Owns the stack pointer, so push/pop addressing and empty/full checks live here rather than in the datapath.

## Interface

Parameters:
- DEPTH, 256: number of 32-bit words; address is 8 bits.
- SP_RESET, 8'h00: stack pointer value after reset; this value also means the stack is empty.
- STACK_LIMIT, 8'hC0: lowest legal stack word; a push with sp == STACK_LIMIT is an overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_op  in  3  0 FETCH, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5–7 illegal.
- req_addr  in  8  word address for FETCH, LOAD and STORE; ignored for PUSH and POP.
- req_wdata  in  32  write data for STORE and PUSH.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read data; 0 for STORE, PUSH and error responses.
- rsp_err  out  1  qualifies rsp_valid; request rejected, no side effect.
- sp  out  8  current stack pointer.

## Operation

- FSM states: IDLE → ACCESS → RESP → IDLE.
- IDLE:
  - req_ready = 1.
  - When req_valid is high at a rising edge, latch op, addr and wdata, then go to ACCESS.
- ACCESS performs exactly one array operation:
  - FETCH/LOAD: rdata ← mem[addr].
  - STORE: mem[addr] ← wdata.
  - PUSH: if sp == STACK_LIMIT, flag an error. Otherwise sp ← sp−1 (mod 256) and mem[sp−1] ← wdata (pre-decrement).
  - POP: if sp == SP_RESET, flag an error. Otherwise rdata ← mem[sp] and sp ← sp+1 (mod 256).
  - Illegal op: flag an error.
  - The state always moves to RESP.
- RESP: rsp_valid = 1 with rsp_rdata and rsp_err valid, then return to IDLE unconditionally. There is no response backpressure.
- An error response leaves the array and sp untouched, with rsp_rdata = 0.
- Array contents are not reset. The array holds only what was written since power-up.
- All address arithmetic is 8-bit with wrap-around. There are no byte enables; access is whole-word only.

## Timing

- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, sp SP_RESET.
- Edge by edge, for a request accepted at edge E0:
  - E1: array access and sp update.
  - Between E1 and E2: rsp_valid is high.
  - E2: back to IDLE; a new request can be accepted at E3.
- Latency is 2 cycles from acceptance to response, and throughput is one request per 3 cycles.
- req_ready is low in ACCESS and RESP. Requests presented then are not sampled and must be held by the requester.
- Read-after-write: a LOAD accepted after a STORE's response returns the new data. There is no overlapping access, so no forwarding is needed.
- Reset asserted mid-operation:
  - If asserted before E1, the pending write or sp update is discarded and outputs drop to reset values immediately.
  - If asserted after E1, a completed write persists.

## Configuration

- MEM_STACK_EN defined:
  - PUSH and POP behave as above.
  - sp is a live register.
- MEM_STACK_EN undefined:
  - Ops 3 and 4 are treated as illegal (rsp_err = 1, no side effect).
  - The sp register is removed and the sp output is tied to SP_RESET.
  - STACK_LIMIT is unused.

## Test plan

- Reset, then STORE addr 8'h10 wdata 32'hDEADBEEF, then LOAD 8'h10 → STORE response rdata 0, err 0; LOAD rsp_rdata = 32'hDEADBEEF, exactly 2 cycles after acceptance.
- req_valid held high continuously with alternating FETCH requests → req_ready pattern 1,0,0 repeating; one rsp_valid pulse per 3 cycles.
- PUSH 32'h1, PUSH 32'h2, POP, POP (MEM_STACK_EN) → sp goes 00→FF→FE→FF→00; pops return 32'h2 then 32'h1.
- POP at sp = 8'h00 → rsp_err 1, rsp_rdata 0, sp stays 00. 64 pushes bring sp to 8'hC0; a 65th push → rsp_err 1, sp stays C0, mem[8'hBF] unchanged.
- req_op 3'd6, and PUSH with MEM_STACK_EN undefined → rsp_err 1 in both cases; memory and sp output unchanged (sp = 8'h00).
- Drop rst_n during ACCESS of a STORE to 8'h20 (old value 32'h5) → rsp_valid never asserts; a later LOAD of 8'h20 returns 32'h5.
